// File: rtl/ram_hw_arbiter.sv
// ram_hw_arbiter
// Lets two masters share one dual-port byte RAM as a half-word memory.
// Each command uses two neighbouring bytes. The high byte is at addr on port A.
// The low byte is at addr+1 on port B. The address wraps at the top of the RAM.
// Arbitration is round-robin between the two masters.
//
// Ports
//   clk, reset_n            single clock, synchronous active-low reset
//   mX_req                  request, held with its command until mX_gnt
//   mX_we / mX_be           write flag and per-byte enables ([1] high byte)
//   mX_addr                 byte address of the high byte
//   mX_wdata                big-endian write half-word
//   mX_gnt                  one-cycle pulse when the command is accepted
//   mX_rvalid / mX_rdata    one-cycle read-valid pulse and the held read half-word
//   busy                    high while a command is in flight
//   ram_we/addr/data_a|b    drive the two RAM ports
//   ram_q_a / ram_q_b       RAM read data, one cycle after the address
module ram_hw_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [1:0]              m0_be,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [2*DATA_WIDTH-1:0] m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [2*DATA_WIDTH-1:0] m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [1:0]              m1_be,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [2*DATA_WIDTH-1:0] m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [2*DATA_WIDTH-1:0] m1_rdata,
    output logic                    busy,
    output logic                    ram_we_a,
    output logic                    ram_we_b,
    output logic [ADDR_WIDTH-1:0]   ram_addr_a,
    output logic [ADDR_WIDTH-1:0]   ram_addr_b,
    output logic [DATA_WIDTH-1:0]   ram_data_a,
    output logic [DATA_WIDTH-1:0]   ram_data_b,
    input  logic [DATA_WIDTH-1:0]   ram_q_a,
    input  logic [DATA_WIDTH-1:0]   ram_q_b
);

    localparam int HW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic                   we_q, we_d;
    logic [1:0]             be_q, be_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [HW-1:0]          wdata_q, wdata_d;
    logic                   m0_gnt_q, m0_gnt_d;
    logic                   m1_gnt_q, m1_gnt_d;
    logic                   m0_rvalid_q, m0_rvalid_d;
    logic                   m1_rvalid_q, m1_rvalid_d;
    logic [HW-1:0]          m0_rdata_q, m0_rdata_d;
    logic [HW-1:0]          m1_rdata_q, m1_rdata_d;
    logic                   winner;

    // State register. Reset makes last_q point at m1, so m0 wins the first tie.
    // Reset also drops any command that is in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            be_q        <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE.
    // On a tie the master that was not granted last wins. A lone request wins whatever the history.
    // Read data is taken at the end of RDATA, when the RAM has had one cycle to respond.
    // Only the owner's rdata register is loaded.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        winner      = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    winner   = (m0_req && m1_req) ? ~last_q : m1_req;
                    owner_d  = winner;
                    last_d   = winner;
                    we_d     = winner ? m1_we    : m0_we;
                    be_d     = winner ? m1_be    : m0_be;
                    addr_d   = winner ? m1_addr  : m0_addr;
                    wdata_d  = winner ? m1_wdata : m0_wdata;
                    m0_gnt_d = ~winner;
                    m1_gnt_d = winner;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                state_d = we_q ? IDLE : RDATA;
            end
            RDATA: begin
                state_d = IDLE;
                if (owner_q) begin
                    m1_rdata_d  = {ram_q_a, ram_q_b};
                    m1_rvalid_d = 1'b1;
                end else begin
                    m0_rdata_d  = {ram_q_a, ram_q_b};
                    m0_rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port drive. Outputs are driven only in ACCESS and are zero in every other state.
    // Port B gets the next byte address, which wraps at the top of the RAM.
    // Each byte enable gates its own port, so be = 00 writes nothing.
    always_comb begin
        ram_we_a   = 1'b0;
        ram_we_b   = 1'b0;
        ram_addr_a = '0;
        ram_addr_b = '0;
        ram_data_a = '0;
        ram_data_b = '0;
        if (state_q == ACCESS) begin
            ram_addr_a = addr_q;
            ram_addr_b = addr_q + ADDR_WIDTH'(1);
            if (we_q) begin
                ram_data_a = wdata_q[HW-1:DATA_WIDTH];
                ram_data_b = wdata_q[DATA_WIDTH-1:0];
                ram_we_a   = be_q[1];
                ram_we_b   = be_q[0];
            end
        end
    end

    // Registered handshake outputs, plus busy decoded from the state.
    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
